// File: rtl/prompt_dump_latch_if.sv
// Bus between the prompt correlator/acquisition control and the
// integrate-and-dump latch: enable, sample handshake, and latched results.
interface prompt_dump_latch_if #(
   parameter int PROD_W = 6
);
   logic                     en;
   logic                     samp_valid;
   logic signed [PROD_W-1:0] i_prod;
   logic signed [PROD_W-1:0] q_prod;
   logic                     epoch;
   logic [19:0]              ain;
   logic [19:0]              bin;
   logic                     aen;
   logic [15:0]              dump_count;
   logic                     sat;
   logic                     ovr;

   modport master (
      output en, samp_valid, i_prod, q_prod, epoch,
      input  ain, bin, aen, dump_count, sat, ovr
   );

   modport slave (
      input  en, samp_valid, i_prod, q_prod, epoch,
      output ain, bin, aen, dump_count, sat, ovr
   );
endinterface

// File: rtl/prompt_dump_latch.sv
// Integrate-and-dump front end: accumulates signed I/Q prompt products over
// DUMP_EPOCHS code epochs, latches saturated 20-bit sums and strobes aen so
// the threshold block registers on the rising edge and compares on the fall.
module prompt_dump_latch #(
   parameter int PROD_W      = 6,
   parameter int ACC_W       = 26,
   parameter int DUMP_EPOCHS = 1,
   parameter int AEN_WIDTH   = 4
) (
   input logic                 mclk,
   input logic                 res,
   prompt_dump_latch_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      ALIGN,
      ACCUM
   } state_t;

   // Sequencer: 0 = free, 1 = setup cycle, 2..AEN_WIDTH+1 = aen high.
   localparam int                     SEQ_W    = $clog2(AEN_WIDTH + 2);
   localparam logic [SEQ_W-1:0]       SEQ_LAST = SEQ_W'(AEN_WIDTH + 1);
   localparam logic [SEQ_W-1:0]       SEQ_ONE  = SEQ_W'(1);
   localparam logic [SEQ_W-1:0]       SEQ_AEN  = SEQ_W'(2);
   localparam logic [4:0]             EP_LAST  = 5'(DUMP_EPOCHS - 1);
   localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(524287);
   localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  sum_i_q, sum_i_d;
   logic signed [ACC_W-1:0]  sum_q_q, sum_q_d;
   logic [4:0]               ep_cnt_q, ep_cnt_d;
   logic [SEQ_W-1:0]         seq_q, seq_d;
   logic                     aen_q, aen_d;
   logic [19:0]              ain_q, ain_d;
   logic [19:0]              bin_q, bin_d;
   logic [15:0]              dump_cnt_q, dump_cnt_d;
   logic                     sat_q, sat_d;
   logic                     ovr_q, ovr_d;

   logic                     dump_req;
   logic signed [ACC_W-1:0]  prod_i;
   logic signed [ACC_W-1:0]  prod_q;
   logic [20:0]              clamp_i;
   logic [20:0]              clamp_q;
   logic                     seq_busy;

   // Symmetric clamp to +/-524287; MSB of the result flags a clamp.
   function automatic logic [20:0] clamp20(input logic signed [ACC_W-1:0] s);
      logic [20:0] r;
      if (s > POS_LIM) begin
         r = {1'b1, 20'h7FFFF};
      end else if (s < NEG_LIM) begin
         r = {1'b1, 20'h80001};
      end else begin
         r = {1'b0, s[19:0]};
      end
      return r;
   endfunction

   assign prod_i = bus.samp_valid ?
                   {{(ACC_W-PROD_W){bus.i_prod[PROD_W-1]}}, bus.i_prod} : '0;
   assign prod_q = bus.samp_valid ?
                   {{(ACC_W-PROD_W){bus.q_prod[PROD_W-1]}}, bus.q_prod} : '0;

   assign clamp_i  = clamp20(sum_i_q);
   assign clamp_q  = clamp20(sum_q_q);
   assign seq_busy = (seq_q != '0);

   // Acquisition FSM, epoch counting and accumulation; raises dump_req.
   always_comb begin
      state_d  = state_q;
      sum_i_d  = sum_i_q;
      sum_q_d  = sum_q_q;
      ep_cnt_d = ep_cnt_q;
      dump_req = 1'b0;
      if (!bus.en) begin
         state_d  = IDLE;
         sum_i_d  = '0;
         sum_q_d  = '0;
         ep_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = ALIGN;
               sum_i_d  = '0;
               sum_q_d  = '0;
               ep_cnt_d = '0;
            end
            ALIGN: begin
               if (bus.epoch) begin
                  state_d  = ACCUM;
                  sum_i_d  = prod_i;
                  sum_q_d  = prod_q;
                  ep_cnt_d = '0;
               end
            end
            ACCUM: begin
               if (bus.epoch && (ep_cnt_q >= EP_LAST)) begin
                  // The sample coinciding with epoch opens the new period.
                  dump_req = 1'b1;
                  sum_i_d  = prod_i;
                  sum_q_d  = prod_q;
                  ep_cnt_d = '0;
               end else begin
                  if (bus.epoch) begin
                     ep_cnt_d = ep_cnt_q + 5'd1;
                  end
                  sum_i_d = sum_i_q + prod_i;
                  sum_q_d = sum_q_q + prod_q;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Result latch and strobe sequencer; a dump while busy is dropped as overrun.
   always_comb begin
      seq_d      = seq_q;
      ain_d      = ain_q;
      bin_d      = bin_q;
      dump_cnt_d = dump_cnt_q;
      sat_d      = sat_q;
      ovr_d      = ovr_q;
      if (seq_busy) begin
         seq_d = (seq_q == SEQ_LAST) ? '0 : seq_q + SEQ_ONE;
      end
      if (dump_req) begin
         if (!seq_busy) begin
            ain_d      = clamp_i[19:0];
            bin_d      = clamp_q[19:0];
            dump_cnt_d = dump_cnt_q + 16'd1;
            sat_d      = sat_q | clamp_i[20] | clamp_q[20];
            seq_d      = SEQ_ONE;
         end else begin
            ovr_d = 1'b1;
         end
      end
      aen_d = (seq_d >= SEQ_AEN);
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge mclk) begin
      if (res) begin
         state_q    <= IDLE;
         sum_i_q    <= '0;
         sum_q_q    <= '0;
         ep_cnt_q   <= '0;
         seq_q      <= '0;
         aen_q      <= 1'b0;
         ain_q      <= '0;
         bin_q      <= '0;
         dump_cnt_q <= '0;
         sat_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sum_i_q    <= sum_i_d;
         sum_q_q    <= sum_q_d;
         ep_cnt_q   <= ep_cnt_d;
         seq_q      <= seq_d;
         aen_q      <= aen_d;
         ain_q      <= ain_d;
         bin_q      <= bin_d;
         dump_cnt_q <= dump_cnt_d;
         sat_q      <= sat_d;
         ovr_q      <= ovr_d;
      end
   end

   assign bus.ain        = ain_q;
   assign bus.bin        = bin_q;
   assign bus.aen        = aen_q;
   assign bus.dump_count = dump_cnt_q;
   assign bus.sat        = sat_q;
   assign bus.ovr        = ovr_q;

endmodule
